// File: rtl/data_mem_resp.sv
// Single-port word memory behind an as_/rdy_ strobe handshake, with byte enables and error reporting.
// Optional wait states are compiled in with MEM_WAIT_STATE_EN (count set by WAIT_CYCLES).
module data_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [2:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on a rising edge where the block is IDLE and as_==0;
  // rdy_ is low for exactly one cycle per request (err valid only then), and the
  // initiator releases or re-drives as_ in that cycle; as_ is ignored outside IDLE.

  localparam int DEPTH = 1 << ADDR_W;

`ifdef MEM_WAIT_STATE_EN
  localparam bit USE_WAIT = (WAIT_CYCLES > 0);
  localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd2
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [31:0]       mem [DEPTH];

  logic              acc_rw;
  logic [31:0]       acc_addr;
  logic [2:0]        acc_size;
  logic [31:0]       acc_data;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        acc_be;
  logic              range_err;
  logic              size_err;
  logic              acc_err;
  logic              enter_resp;

  assign state_dbg = state;

`ifdef MEM_WAIT_STATE_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             cap_rw;
  logic [31:0]      cap_addr;
  logic [2:0]       cap_size;
  logic [31:0]      cap_data;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wait_cnt <= '0;
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_size <= '0;
      cap_data <= '0;
    end else if (state == IDLE && !as_) begin
      wait_cnt <= WAIT_LD;
      cap_rw   <= rw;
      cap_addr <= addr;
      cap_size <= wr_size;
      cap_data <= wr_data;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Without wait states the access happens on the capture edge, so IDLE uses live inputs.
  always_comb begin
    acc_rw   = cap_rw;
    acc_addr = cap_addr;
    acc_size = cap_size;
    acc_data = cap_data;
    if (state == IDLE) begin
      acc_rw   = rw;
      acc_addr = addr;
      acc_size = wr_size;
      acc_data = wr_data;
    end
  end
`else
  always_comb begin
    acc_rw   = rw;
    acc_addr = addr;
    acc_size = wr_size;
    acc_data = wr_data;
  end
`endif

  always_comb begin
    acc_idx   = acc_addr[ADDR_W+1:2];
    range_err = |(acc_addr >> (ADDR_W + 2));
    acc_be    = 4'b0000;
    size_err  = 1'b1;
    unique case (acc_size)
      3'b000: begin
        acc_be   = 4'b0001 << acc_addr[1:0];
        size_err = 1'b0;
      end
      3'b001: begin
        acc_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        size_err = acc_addr[0];
      end
      3'b010: begin
        acc_be   = 4'b1111;
        size_err = |acc_addr[1:0];
      end
      default: begin
        acc_be   = 4'b0000;
        size_err = 1'b1;
      end
    endcase
    // Size is meaningless on reads, so only the range can fail them.
    acc_err = range_err | (!acc_rw & size_err);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!as_) begin
`ifdef MEM_WAIT_STATE_EN
          if (USE_WAIT) state_nxt = WAIT;
          else          state_nxt = RESP;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_STATE_EN
      WAIT: begin
        if (wait_cnt == CNT_W'(1)) state_nxt = RESP;
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_resp = (state_nxt == RESP);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      rdy_    <= 1'b1;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      rdy_  <= !enter_resp;
      err   <= enter_resp & acc_err;
      if (enter_resp && acc_rw) begin
        rd_data <= acc_err ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Array has no reset; reset_ gates the commit so an edge during reset never writes.
  always_ff @(posedge clk) begin
    if (reset_ && enter_resp && !acc_rw && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_be[k]) mem[acc_idx][8*k +: 8] <= acc_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios plus random traffic against a behavioural memory model.
module tb_data_mem_resp;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = 1 + WAIT_CYCLES;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset_;
  logic        as_;
  logic        rw;
  logic [31:0] addr;
  logic [2:0]  wr_size;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        err;
  logic [1:0]  state_dbg;

  data_mem_resp #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .as_       (as_),
    .rw        (rw),
    .addr      (addr),
    .wr_size   (wr_size),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rdy_      (rdy_),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  typedef struct {
    int          cyc;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [1 << ADDR_W];
  logic [31:0] held;
  int          next_idle;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h cycle=%0d", name, act, expv, cyc);
    end
  endtask

  function automatic bit model_err(input bit r, input logic [31:0] a, input logic [2:0] sz);
    if (a >= (32'd1 << (ADDR_W + 2))) return 1'b1;
    if (r) return 1'b0;
    case (sz)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int idx, first, n;
    idx = int'(a[ADDR_W+1:2]);
    first = 0;
    n = 4;
    if (sz == 3'd0) begin first = int'(a[1:0]);        n = 1; end
    if (sz == 3'd1) begin first = a[1] ? 2 : 0;        n = 2; end
    for (int k = first; k < first + n; k++) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
  endtask

  // compare process: every cycle, rdy_/err/rd_data against the model's schedule
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_rdy: got=none expected=cycle %0d cycle=%0d", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdy_low", {31'd0, rdy_}, 32'd0);
        check("err", {31'd0, err}, {31'd0, e.err});
        if (e.rd) held = e.data;
      end else begin
        check("rdy_high", {31'd0, rdy_}, 32'd1);
      end
      check("rd_data", rd_data, held);
    end
  end

  // driver: issue one request, update the model, wait (bounded) for the rdy_ pulse
  task automatic access(input bit r, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input bit keep,
                        output bit o_err, output logic [31:0] o_data,
                        output int o_lat, output int o_done);
    int   cap;
    exp_t e;
    as_     = 1'b0;
    rw      = r;
    addr    = a;
    wr_size = sz;
    wr_data = d;
    cap     = (cyc + 1 > next_idle) ? cyc + 1 : next_idle;
    e.cyc   = cap + LAT - 1;
    e.err   = model_err(r, a, sz);
    e.rd    = r;
    e.data  = (r && !e.err) ? ref_mem[int'(a[ADDR_W+1:2])] : 32'd0;
    if (!r && !e.err) model_write(a, sz, d);
    exp_q.push_back(e);
    next_idle = e.cyc + 2;
    o_lat = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy_ === 1'b0) begin
        o_lat = cyc - cap + 1;
        break;
      end
    end
    if (o_lat < 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got=no rdy_ expected=rdy_ low by cycle %0d cycle=%0d", e.cyc, cyc);
    end
    o_err  = err;
    o_data = rd_data;
    o_done = cyc;
    if (!keep) as_ = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=no finish expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          e1;
    logic [31:0] d1;
    int          l1, t1, t2;

    reset_ = 1'b0;
    as_    = 1'b1;
    rw     = 1'b1;
    addr   = '0;
    wr_size = '0;
    wr_data = '0;
    held   = '0;
    next_idle = 0;

    repeat (3) @(negedge clk);
    check("reset_rdy", {31'd0, rdy_}, 32'd1);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);

    // release reset and request on the same cycle: first edge with reset_ high accepts
    reset_ = 1'b1;
    next_idle = cyc + 1;
    access(1'b0, 32'h10, 3'b010, 32'hDEADBEEF, 1'b0, e1, d1, l1, t1);
    check("first_lat", l1, LAT);
    check("word_wr_err", {31'd0, e1}, 32'd0);
    access(1'b1, 32'h10, 3'b010, 32'h0, 1'b0, e1, d1, l1, t1);
    check("word_rd_err", {31'd0, e1}, 32'd0);
    check("word_rd_data", d1, 32'hDEADBEEF);
`ifdef MEM_WAIT_STATE_EN
    check("wait_lat", l1, 32'd3);
`else
    check("nowait_lat", l1, 32'd1);
`endif

    // byte lane write
    access(1'b0, 32'h20, 3'b010, 32'h11223344, 1'b0, e1, d1, l1, t1);
    access(1'b0, 32'h22, 3'b000, 32'hAAAAAAAA, 1'b0, e1, d1, l1, t1);
    access(1'b1, 32'h20, 3'b010, 32'h0, 1'b0, e1, d1, l1, t1);
    check("byte_rd_data", d1, 32'h11AA3344);

    // misaligned half write leaves memory untouched
    access(1'b0, 32'h30, 3'b010, 32'hCAFEF00D, 1'b0, e1, d1, l1, t1);
    access(1'b0, 32'h31, 3'b001, 32'h12345678, 1'b0, e1, d1, l1, t1);
    check("half_mis_err", {31'd0, e1}, 32'd1);
    access(1'b1, 32'h30, 3'b010, 32'h0, 1'b0, e1, d1, l1, t1);
    check("half_mis_mem", d1, 32'hCAFEF00D);

    // out-of-range read
    access(1'b1, 32'h00001000, 3'b010, 32'h0, 1'b0, e1, d1, l1, t1);
    check("range_err", {31'd0, e1}, 32'd1);
    check("range_rd_data", d1, 32'd0);

    // back-to-back with as_ held low
    access(1'b0, 32'h50, 3'b010, 32'h01020304, 1'b1, e1, d1, l1, t1);
    access(1'b1, 32'h50, 3'b010, 32'h0, 1'b0, e1, d1, l1, t2);
    check("b2b_spacing", t2 - t1, LAT + 1);
    check("b2b_rd_data", d1, 32'h01020304);

    // reset in the middle of a write: the pending write is dropped
    access(1'b0, 32'h40, 3'b010, 32'h0BADF00D, 1'b0, e1, d1, l1, t1);
    @(negedge clk);
    as_ = 1'b0;
    rw = 1'b0;
    addr = 32'h40;
    wr_size = 3'b010;
    wr_data = 32'h55555555;
`ifdef MEM_WAIT_STATE_EN
    @(negedge clk);
    as_ = 1'b1;
`endif
    #2;
    reset_ = 1'b0;
    held = '0;
    exp_q.delete();
    #1;
    check("midreset_rdy", {31'd0, rdy_}, 32'd1);
    check("midreset_rd_data", rd_data, 32'd0);
    repeat (2) @(negedge clk);
    as_ = 1'b1;
    reset_ = 1'b1;
    next_idle = cyc + 1;
    access(1'b1, 32'h40, 3'b010, 32'h0, 1'b0, e1, d1, l1, t1);
    check("midreset_old", d1, 32'h0BADF00D);

    // fill every word, then random mixed traffic
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      access(1'b0, 32'(i) << 2, 3'b010, $urandom(), 1'b1, e1, d1, l1, t1);
    end
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {20'd0, 10'($urandom_range(0, (1 << ADDR_W) - 1)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 28) | 32'h1000;
      access(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom(), 1'b1,
             e1, d1, l1, t1);
      check("rand_lat", l1, LAT);
      if ($urandom_range(0, 3) == 0) begin
        as_ = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    as_ = 1'b1;
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
